// File: rtl/muldiv_ctrl_pkg.sv
// Shared op-bit indices, FSM states and helpers for the HI/LO multiply/divide controller.
package muldiv_ctrl_pkg;

    localparam int MD_OP_W = 12;

    localparam logic [3:0] MD_MULT  = 4'd0;
    localparam logic [3:0] MD_MULTU = 4'd1;
    localparam logic [3:0] MD_DIV   = 4'd2;
    localparam logic [3:0] MD_DIVU  = 4'd3;
    localparam logic [3:0] MD_MTHI  = 4'd4;
    localparam logic [3:0] MD_MTLO  = 4'd5;
    localparam logic [3:0] MD_MADD  = 4'd8;
    localparam logic [3:0] MD_MADDU = 4'd9;
    localparam logic [3:0] MD_MSUB  = 4'd10;
    localparam logic [3:0] MD_MSUBU = 4'd11;
    localparam logic [3:0] MD_NONE  = 4'd15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL1,
        ST_MUL2,
        ST_DIV,
        ST_FIX
    } md_state_e;

    typedef enum logic [1:0] {
        ACC_SET,
        ACC_ADD,
        ACC_SUB
    } md_acc_e;

    // Lowest set bit wins; an empty op maps to MD_NONE.
    function automatic logic [3:0] md_first_bit(input logic [MD_OP_W-1:0] op_in);
        logic [3:0] idx;
        idx = MD_NONE;
        for (int i = MD_OP_W - 1; i >= 0; i--) begin
            if (op_in[i]) idx = 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/muldiv_ctrl_div_iter.sv
// div_iter: iterative restoring divider core on unsigned magnitudes, one quotient bit per cycle.
module div_iter
    import muldiv_ctrl_pkg::*;
#(
    parameter int ITERS = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        kill,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    localparam int CW = $clog2(ITERS) + 1;

    logic          r_run;
    logic [CW-1:0] r_cnt;
    logic [31:0]   r_q;
    logic [31:0]   r_rem;
    logic [31:0]   r_d;
    logic [32:0]   w_part;
    logic [32:0]   w_diff;
    logic          w_ge;

    // Shift in the next dividend bit; a clear borrow bit means the divisor fits.
    assign w_part = {r_rem, r_q[31]};
    assign w_diff = w_part - {1'b0, r_d};
    assign w_ge   = !w_diff[32];

    assign done      = r_run && (r_cnt == CW'(ITERS - 1));
    assign quotient  = r_q;
    assign remainder = r_rem;

    always_ff @(posedge clk) begin
        if (reset || kill) begin
            r_run <= 1'b0;
            r_cnt <= '0;
        end else if (start) begin
            r_run <= 1'b1;
            r_cnt <= '0;
        end else if (r_run) begin
            r_cnt <= r_cnt + CW'(1);
            if (done) r_run <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (start) begin
            r_q   <= dividend;
            r_rem <= '0;
            r_d   <= divisor;
        end else if (r_run) begin
            r_q   <= {r_q[30:0], w_ge};
            r_rem <= w_ge ? w_diff[31:0] : w_part[31:0];
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO multiply/divide sequencer beside the EX ALU: 2-cycle multiply, iterative divide, MTHI/MTLO.
// Define MULDIV_MADD_EN to enable MADD/MADDU/MSUB/MSUBU accumulation into {hi,lo}.
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int DIV_ITERS = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               op_valid,
    input  logic [MD_OP_W-1:0] op,
    input  logic [31:0]        a,
    input  logic [31:0]        b,
    output logic               op_ready,
    input  logic               cancel,
    output logic               busy,
    output logic [31:0]        hi,
    output logic [31:0]        lo
);

    md_state_e          r_state, w_next;
    logic               w_accept;
    logic [3:0]         w_idx;
    logic               w_is_mul, w_is_div, w_signed, w_mthi, w_mtlo;
    md_acc_e            w_acc;
    logic signed [32:0] r_ma, r_mb;
    md_acc_e            r_acc;
    logic [63:0]        r_prod;
    logic [31:0]        r_a, r_b;
    logic               r_signed;
    logic signed [63:0] w_ma64, w_mb64;
    logic [63:0]        w_prod, w_mul_res;
    logic [31:0]        w_abs_a, w_abs_b;
    logic               w_div_done;
    logic [31:0]        w_quo, w_rem, w_fix_hi, w_fix_lo;

    assign w_accept = op_valid && op_ready && !cancel;
    assign w_idx    = md_first_bit(op);

    always_comb begin
        w_is_mul = 1'b0;
        w_is_div = 1'b0;
        w_signed = 1'b0;
        w_mthi   = 1'b0;
        w_mtlo   = 1'b0;
        w_acc    = ACC_SET;
        case (w_idx)
            MD_MULT:  begin w_is_mul = 1'b1; w_signed = 1'b1; end
            MD_MULTU: begin w_is_mul = 1'b1; end
            MD_DIV:   begin w_is_div = 1'b1; w_signed = 1'b1; end
            MD_DIVU:  begin w_is_div = 1'b1; end
            MD_MTHI:  begin w_mthi = 1'b1; end
            MD_MTLO:  begin w_mtlo = 1'b1; end
`ifdef MULDIV_MADD_EN
            MD_MADD:  begin w_is_mul = 1'b1; w_signed = 1'b1; w_acc = ACC_ADD; end
            MD_MADDU: begin w_is_mul = 1'b1; w_acc = ACC_ADD; end
            MD_MSUB:  begin w_is_mul = 1'b1; w_signed = 1'b1; w_acc = ACC_SUB; end
            MD_MSUBU: begin w_is_mul = 1'b1; w_acc = ACC_SUB; end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && w_is_mul)      w_next = ST_MUL1;
                else if (w_accept && w_is_div) w_next = ST_DIV;
            end
            ST_MUL1: w_next = ST_MUL2;
            ST_MUL2: w_next = ST_IDLE;
            ST_DIV:  if (w_div_done) w_next = ST_FIX;
            ST_FIX:  w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
        if (cancel && r_state != ST_IDLE) w_next = ST_IDLE;
    end

    always_comb begin
        op_ready = (r_state == ST_IDLE);
        busy     = !op_ready;
    end

    // Operand capture at accept; product registered in MUL1.
    always_ff @(posedge clk) begin
        if (w_accept && w_is_mul) begin
            r_ma  <= w_signed ? {a[31], a} : {1'b0, a};
            r_mb  <= w_signed ? {b[31], b} : {1'b0, b};
            r_acc <= w_acc;
        end
        if (w_accept && w_is_div) begin
            r_a      <= a;
            r_b      <= b;
            r_signed <= w_signed;
        end
        if (r_state == ST_MUL1) r_prod <= w_prod;
    end

    assign w_ma64 = 64'(r_ma);
    assign w_mb64 = 64'(r_mb);
    assign w_prod = w_ma64 * w_mb64;

    always_comb begin
        case (r_acc)
            ACC_ADD: w_mul_res = {hi, lo} + r_prod;
            ACC_SUB: w_mul_res = {hi, lo} - r_prod;
            default: w_mul_res = r_prod;
        endcase
    end

    assign w_abs_a = (w_signed && a[31]) ? -a : a;
    assign w_abs_b = (w_signed && b[31]) ? -b : b;

    div_iter #(
        .ITERS(DIV_ITERS)
    ) u_div (
        .clk       (clk),
        .reset     (reset),
        .start     (w_accept && w_is_div),
        .kill      (cancel),
        .dividend  (w_abs_a),
        .divisor   (w_abs_b),
        .done      (w_div_done),
        .quotient  (w_quo),
        .remainder (w_rem)
    );

    // Divide by zero bypasses the sign fixup and reports the raw dividend.
    always_comb begin
        w_fix_lo = (r_signed && (r_a[31] ^ r_b[31])) ? -w_quo : w_quo;
        w_fix_hi = (r_signed && r_a[31]) ? -w_rem : w_rem;
        if (r_b == '0) begin
            w_fix_lo = '1;
            w_fix_hi = r_a;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
        end else if (w_accept && w_mthi) begin
            hi <= a;
        end else if (w_accept && w_mtlo) begin
            lo <= a;
        end else if (r_state == ST_MUL2 && !cancel) begin
            {hi, lo} <= w_mul_res;
        end else if (r_state == ST_FIX && !cancel) begin
            hi <= w_fix_hi;
            lo <= w_fix_lo;
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: stimulus queues expected HI/LO, a negedge monitor checks on completion.
module tb_muldiv_ctrl;

    localparam int DIV_ITERS = 32;

    localparam logic [11:0] OP_MULT  = 12'h001;
    localparam logic [11:0] OP_MULTU = 12'h002;
    localparam logic [11:0] OP_DIV   = 12'h004;
    localparam logic [11:0] OP_DIVU  = 12'h008;
    localparam logic [11:0] OP_MTHI  = 12'h010;
    localparam logic [11:0] OP_MTLO  = 12'h020;
    localparam logic [11:0] OP_MADD  = 12'h100;
    localparam logic [11:0] OP_MADDU = 12'h200;
    localparam logic [11:0] OP_MSUB  = 12'h400;

    typedef struct {
        string       nm;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        op_valid = 1'b0;
    logic [11:0] op = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        cancel = 1'b0;
    logic        op_ready, busy;
    logic [31:0] hi, lo;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic m_busy_d = 1'b0;
    logic m_acc_d = 1'b0;

    muldiv_ctrl #(
        .DIV_ITERS(DIV_ITERS)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .op_valid (op_valid),
        .op       (op),
        .a        (a),
        .b        (b),
        .op_ready (op_ready),
        .cancel   (cancel),
        .busy     (busy),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, expv);
        end
    endtask

    // Completion = busy just dropped, or a single-cycle op was accepted last cycle.
    always @(negedge clk) begin
        exp_t e;
        if ((m_busy_d && !busy) || (m_acc_d && !busy)) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected completion: hi=%h lo=%h", hi, lo);
            end else begin
                e = exp_q.pop_front();
                chk({e.nm, " hi"}, hi, e.hi);
                chk({e.nm, " lo"}, lo, e.lo);
                chk({e.nm, " op_ready"}, 32'(op_ready), 32'd1);
            end
        end
        m_busy_d = busy;
        m_acc_d  = op_valid && op_ready && !cancel && !reset;
    end

    task automatic do_op(input string nm, input logic [11:0] opv, input logic [31:0] av,
                         input logic [31:0] bv, input logic [31:0] ehi, input logic [31:0] elo,
                         input int ebusy);
        int n;
        exp_q.push_back('{nm, ehi, elo});
        op_valid = 1'b1;
        op = opv;
        a = av;
        b = bv;
        @(posedge clk); #1;
        op_valid = 1'b0;
        op = '0;
        n = 0;
        while (busy && n < 200) begin
            n++;
            @(posedge clk); #1;
        end
        chk({nm, " busy cycles"}, 32'(n), 32'(ebusy));
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset hi", hi, 32'h0);
        chk("reset lo", lo, 32'h0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset op_ready", 32'(op_ready), 32'd1);
        reset = 1'b0;
        @(posedge clk); #1;

        do_op("MULT", OP_MULT, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 2);
        do_op("MULTU", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 2);
        do_op("DIVU", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, DIV_ITERS + 1);
        do_op("DIV neg", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, DIV_ITERS + 1);
        do_op("DIV by0", OP_DIV, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, DIV_ITERS + 1);
        do_op("DIV ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, DIV_ITERS + 1);
        do_op("nop", 12'h000, 32'h55, 32'h66, 32'h0, 32'h80000000, 0);
        do_op("rsvd wins", 12'h180, 32'h55, 32'h66, 32'h0, 32'h80000000, 0);
        do_op("MULT prio", OP_MULT | OP_DIV, 32'd3, 32'd4, 32'h0, 32'd12, 2);
        do_op("MTLO", OP_MTLO, 32'h0000ABCD, 32'h0, 32'h0, 32'h0000ABCD, 0);

        // MTHI, then DIV cancelled in cycle 10 counted from the MTHI cycle.
        exp_q.push_back('{"MTHI", 32'h1234, 32'h0000ABCD});
        op_valid = 1'b1; op = OP_MTHI; a = 32'h1234;
        @(posedge clk); #1;
        exp_q.push_back('{"DIV cancel", 32'h1234, 32'h0000ABCD});
        op = OP_DIV; a = 32'd100; b = 32'd7;
        @(posedge clk); #1;
        op_valid = 1'b0; op = '0;
        repeat (8) begin @(posedge clk); #1; end
        cancel = 1'b1;
        @(posedge clk); #1;
        cancel = 1'b0;
        chk("cancel busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        chk("cancel op_ready", 32'(op_ready), 32'd1);
        @(posedge clk); #1;

        // Cancel landing in the FIX cycle must suppress the write.
        exp_q.push_back('{"DIV fixcancel", 32'h1234, 32'h0000ABCD});
        op_valid = 1'b1; op = OP_DIVU; a = 32'd100; b = 32'd7;
        @(posedge clk); #1;
        op_valid = 1'b0; op = '0;
        repeat (DIV_ITERS) begin @(posedge clk); #1; end
        chk("fix busy", 32'(busy), 32'd1);
        cancel = 1'b1;
        @(posedge clk); #1;
        cancel = 1'b0;
        chk("fixcancel busy", 32'(busy), 32'd0);
        @(posedge clk); #1;

        do_op("MTHI0", OP_MTHI, 32'h0, 32'h0, 32'h0, 32'h0000ABCD, 0);
        do_op("MTLO1s", OP_MTLO, 32'hFFFFFFFF, 32'h0, 32'h0, 32'hFFFFFFFF, 0);
`ifdef MULDIV_MADD_EN
        do_op("MADDU", OP_MADDU, 32'd1, 32'd1, 32'h1, 32'h0, 2);
        do_op("MSUB", OP_MSUB, 32'd2, 32'd3, 32'h0, 32'hFFFFFFFA, 2);
        do_op("MADD", OP_MADD, 32'hFFFFFFFF, 32'd2, 32'h0, 32'hFFFFFFF8, 2);
`else
        do_op("MADDU", OP_MADDU, 32'd1, 32'd1, 32'h0, 32'hFFFFFFFF, 0);
        do_op("MSUB", OP_MSUB, 32'd2, 32'd3, 32'h0, 32'hFFFFFFFF, 0);
        do_op("MADD", OP_MADD, 32'hFFFFFFFF, 32'd2, 32'h0, 32'hFFFFFFFF, 0);
`endif

        // Reset mid-divide clears HI/LO and returns to IDLE.
        exp_q.push_back('{"reset mid-DIV", 32'h0, 32'h0});
        op_valid = 1'b1; op = OP_DIVU; a = 32'd1000; b = 32'd3;
        @(posedge clk); #1;
        op_valid = 1'b0; op = '0;
        repeat (4) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("reset mid busy", 32'(busy), 32'd0);
        chk("reset mid op_ready", 32'(op_ready), 32'd1);
        repeat (3) begin @(posedge clk); #1; end

        chk("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
